// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared UART TxUnit: latches the winner's byte and frame config, pulses tx_start, acks on done.
// Optional watchdog abort of a stalled frame is enabled with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   timeout,
  output logic                   busy,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_sel,
  input  logic [1:0]             cfg_parity_type,
  input  logic [1:0]             cfg_baud_rate,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic [1:0]             tx_parity_type,
  output logic [1:0]             tx_baud_rate,
  input  logic                   tx_active_flag,
  input  logic                   tx_done_flag,
  output logic [2:0]             dbg_state
);

  localparam int          IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [19:0] TO_LIMIT = 20'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_winner;
  logic [IW-1:0]       r_last;
  logic [IW-1:0]       w_pick;
  logic [1:0]          r_cfg_par  [NUM_REQ];
  logic [1:0]          r_cfg_baud [NUM_REQ];
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  w_onehot;
  logic                r_start;
  logic [7:0]          r_data;
  logic [1:0]          r_par;
  logic [1:0]          r_baud;
  logic [7:0]          w_sel_data;
  logic [1:0]          w_sel_par;
  logic [1:0]          w_sel_baud;
  int                  w_dist;
  int                  w_best;
  logic                w_unused;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [19:0]         r_wd_cnt;
  logic                r_abort;
  logic                r_timeout;
`endif

  // Handshake: a requester raises req and holds it (and its byte) until it sees its one-cycle ack;
  // dropping req after grant does not cancel the frame, dropping it before IDLE samples it does.

  // Winner is the set request closest after r_last in wrap-around order.
  always_comb begin
    w_pick = '0;
    w_best = NUM_REQ;
    w_dist = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - int'(r_last)) % NUM_REQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_pick = IW'(i);
      end
    end
  end

  always_comb begin
    w_onehot   = '0;
    w_sel_data = '0;
    w_sel_par  = '0;
    w_sel_baud = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_winner == IW'(i)) begin
        w_onehot[i] = 1'b1;
        w_sel_data  = req_data[8*i +: 8];
        w_sel_par   = r_cfg_par[i];
        w_sel_baud  = r_cfg_baud[i];
      end
    end
  end

  // Out-of-range cfg_sel matches no entry, so such writes fall away.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        r_cfg_par[i]  <= 2'b00;
        r_cfg_baud[i] <= 2'b11;
      end else if (cfg_we && (cfg_sel == 3'(i))) begin
        r_cfg_par[i]  <= cfg_parity_type;
        r_cfg_baud[i] <= cfg_baud_rate;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_winner <= '0;
      r_last   <= IW'(NUM_REQ - 1);
      r_grant  <= '0;
      r_ack    <= '0;
      r_start  <= 1'b0;
      r_data   <= 8'h00;
      r_par    <= 2'b00;
      r_baud   <= 2'b11;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_wd_cnt  <= '0;
      r_abort   <= 1'b0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      r_ack   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_grant <= '0;
          if (|req) begin
            r_winner <= w_pick;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_grant <= w_onehot;
          r_data  <= w_sel_data;
          r_par   <= w_sel_par;
          r_baud  <= w_sel_baud;
          r_state <= S_START;
        end
        S_START: begin
          r_start <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
          r_wd_cnt <= '0;
          r_abort  <= 1'b0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done_flag) begin
            r_state <= S_ACK;
`ifdef UART_TX_ARB_TIMEOUT_EN
          end else if (r_wd_cnt == TO_LIMIT - 20'd1) begin
            r_abort <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_wd_cnt <= r_wd_cnt + 20'd1;
`endif
          end
        end
        S_ACK: begin
          r_ack   <= w_onehot;
          r_last  <= r_winner;
`ifdef UART_TX_ARB_TIMEOUT_EN
          r_timeout <= r_abort;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant          = r_grant;
  assign ack            = r_ack;
  assign busy           = (r_state != S_IDLE);
  assign tx_start       = r_start;
  assign tx_data        = r_data;
  assign tx_parity_type = r_par;
  assign tx_baud_rate   = r_baud;
  assign dbg_state      = r_state;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout        = r_timeout;
`else
  assign timeout        = 1'b0;
`endif
  // TxUnit activity is informational only; it never steers the sequence.
  assign w_unused       = tx_active_flag ^ (|TO_LIMIT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter with a round-robin/config reference model.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TO_CYC  = 16;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req = '0;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   ack;
  logic                 timeout;
  logic                 busy;
  logic                 cfg_we = 1'b0;
  logic [2:0]           cfg_sel = '0;
  logic [1:0]           cfg_parity_type = '0;
  logic [1:0]           cfg_baud_rate = '0;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic [1:0]           tx_parity_type;
  logic [1:0]           tx_baud_rate;
  logic                 tx_active_flag = 1'b0;
  logic                 tx_done_flag = 1'b0;
  logic [2:0]           dbg_state;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .timeout(timeout), .busy(busy),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_parity_type(cfg_parity_type),
    .cfg_baud_rate(cfg_baud_rate), .tx_start(tx_start), .tx_data(tx_data),
    .tx_parity_type(tx_parity_type), .tx_baud_rate(tx_baud_rate),
    .tx_active_flag(tx_active_flag), .tx_done_flag(tx_done_flag),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference model state
  logic [7:0]         m_data [NUM_REQ];
  logic [1:0]         m_par  [NUM_REQ];
  logic [1:0]         m_baud [NUM_REQ];
  int                 m_last;
  logic [NUM_REQ-1:0] exp_q [$];
  int                 n_tests = 0;
  int                 n_fail  = 0;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = m_data[i];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  // First requester at or after last+1, wrapping around.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_last = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_par[i]  = 2'b00;
      m_baud[i] = 2'b11;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_reset();
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_par", tx_parity_type, 2'b00);
    check("rst_baud", tx_baud_rate, 2'b11);
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [1:0] p, input logic [1:0] b);
    cfg_we = 1'b1; cfg_sel = sel; cfg_parity_type = p; cfg_baud_rate = b;
    step();
    cfg_we = 1'b0;
    if (int'(sel) < NUM_REQ) begin
      m_par[sel]  = p;
      m_baud[sel] = b;
    end
  endtask

  // One frame from IDLE: cfg_mode 0 none, 1 write owner at LOAD edge, 2 write owner parity in WAIT, 3 random write in WAIT.
  task automatic serve_one(input int cfg_mode, input int done_dly, input bit drop_early, input bit keep_req);
    int w;
    logic [7:0] ed;
    logic [1:0] ep, eb, np, nb;
    logic [2:0] ns;
    logic [NUM_REQ-1:0] ack_exp;
    w  = rr_pick(req, m_last);
    ed = m_data[w];
    ep = m_par[w];
    eb = m_baud[w];
    np = '0; nb = '0; ns = '0;
    exp_q.push_back(oh(w));
    step();
    check("grant_idle", grant, 0);
    check("ack_clear", ack, 0);
    if (cfg_mode == 1) begin
      np = 2'($urandom_range(0, 3)); nb = 2'($urandom_range(0, 3));
      cfg_we = 1'b1; cfg_sel = 3'(w); cfg_parity_type = np; cfg_baud_rate = nb;
    end
    step();
    if (cfg_mode == 1) begin
      cfg_we = 1'b0;
      m_par[w] = np; m_baud[w] = nb;
    end
    check("grant", grant, oh(w));
    check("data_load", tx_data, ed);
    check("par_load", tx_parity_type, ep);
    check("baud_load", tx_baud_rate, eb);
    check("start_early", tx_start, 0);
    check("busy", busy, 1);
    if (drop_early) req[w] = 1'b0;
    step();
    check("start", tx_start, 1);
    check("data_start", tx_data, ed);
    tx_active_flag = 1'b1;
    for (int i = 0; i < done_dly; i++) begin
      if (i == 0 && cfg_mode == 2) begin
        ns = 3'(w); np = ~ep; nb = eb;
        cfg_we = 1'b1; cfg_sel = ns; cfg_parity_type = np; cfg_baud_rate = nb;
      end
      if (i == 0 && cfg_mode == 3) begin
        ns = 3'($urandom_range(0, 7)); np = 2'($urandom_range(0, 3)); nb = 2'($urandom_range(0, 3));
        cfg_we = 1'b1; cfg_sel = ns; cfg_parity_type = np; cfg_baud_rate = nb;
      end
      step();
      if (i == 0 && cfg_mode >= 2) begin
        cfg_we = 1'b0;
        if (int'(ns) < NUM_REQ) begin
          m_par[ns] = np; m_baud[ns] = nb;
        end
      end
      check("start_pulse", tx_start, 0);
      check("par_hold", tx_parity_type, ep);
      check("baud_hold", tx_baud_rate, eb);
      check("ack_wait", ack, 0);
    end
    tx_done_flag = 1'b1;
    step();
    tx_done_flag = 1'b0;
    tx_active_flag = 1'b0;
    check("ack_early", ack, 0);
    check("start_done", tx_start, 0);
    step();
    ack_exp = exp_q.pop_front();
    check("ack", ack, ack_exp);
    check("timeout", timeout, 0);
    m_last = w;
    if (!keep_req) req[w] = 1'b0;
  endtask

  initial begin
    logic [NUM_REQ-1:0] r;
    int got;
    for (int i = 0; i < NUM_REQ; i++) m_data[i] = 8'($urandom);
    model_reset();
    do_reset();

    // first frame: requester 0, even parity, 19200
    cfg_write(3'd0, 2'b10, 2'b11);
    m_data[0] = 8'hA5;
    req = 4'b0001;
    serve_one(0, 3, 1'b0, 1'b0);

    // all requesters held: 0,1,2,3,0
    do_reset();
    req = '1;
    for (int i = 0; i < 5; i++) serve_one(0, 5, 1'b0, 1'b1);
    req = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_busy", busy, 0);
      check("idle_grant", grant, 0);
    end

    // 1 served, then 1010 -> 3 then 1
    req = 4'b0010;
    serve_one(0, 2, 1'b0, 1'b0);
    req = 4'b1010;
    serve_one(0, 2, 1'b0, 1'b0);
    serve_one(0, 2, 1'b0, 1'b0);

    // out-of-range cfg_sel ignored, in-range write applied
    cfg_write(3'd5, 2'b01, 2'b00);
    req = 4'b0010;
    serve_one(0, 1, 1'b0, 1'b0);
    cfg_write(3'd1, 2'b11, 2'b01);
    req = 4'b0010;
    serve_one(0, 1, 1'b0, 1'b0);

    // write to owner during WAIT leaves frame alone, applies next LOAD
    cfg_write(3'd2, 2'b10, 2'b11);
    req = 4'b0100;
    serve_one(2, 4, 1'b0, 1'b0);
    req = 4'b0100;
    serve_one(0, 2, 1'b0, 1'b0);

    // write coinciding with LOAD uses old value
    req = 4'b1000;
    serve_one(1, 2, 1'b0, 1'b0);
    req = 4'b1000;
    serve_one(0, 2, 1'b0, 1'b0);

    // req dropped after grant still completes with ack
    req = 4'b0001;
    serve_one(0, 3, 1'b1, 1'b0);

    // reset in WAIT
    req = 4'b0010;
    step(); step(); step();
    tx_active_flag = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    check("rw_grant", grant, 0);
    check("rw_busy", busy, 0);
    check("rw_ack", ack, 0);
    check("rw_start", tx_start, 0);
    check("rw_data", tx_data, 8'h00);
    check("rw_baud", tx_baud_rate, 2'b11);
    reset = 1'b0;
    tx_active_flag = 1'b0;
    req = '0;
    model_reset();
    step();
    check("rw_no_ack", ack, 0);
    check("rw_idle", busy, 0);
    m_data[0] = 8'($urandom);
    req = 4'b0001;
    serve_one(0, 2, 1'b0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      r = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r[i] && !req[i]) m_data[i] = 8'($urandom);
      end
      req = req | r;
      serve_one($urandom_range(0, 3), $urandom_range(1, 6), ($urandom_range(0, 3) == 0), 1'b0);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req != '0) serve_one(0, 1, 1'b0, 1'b0);
    end

    // TxUnit never finishes
    req = 4'b0001;
    step(); step(); step();
`ifdef UART_TX_ARB_TIMEOUT_EN
    got = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (got == 0 && ack != '0) begin
        got = 1;
        check("to_ack", ack, 4'b0001);
        check("to_flag", timeout, 1);
        check("to_latency", (k >= 15 && k <= 19), 1);
      end
    end
    check("to_seen", got, 1);
    m_last = 0;
    req = '0;
`else
    got = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      check("stall_busy", busy, 1);
      check("stall_ack", ack, 0);
      check("stall_timeout", timeout, 0);
    end
    tx_done_flag = 1'b1;
    step();
    tx_done_flag = 1'b0;
    step();
    check("stall_release_ack", ack, 4'b0001);
    m_last = 0;
    req = '0;
`endif
    step();
    step();
    check("end_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
